// File: rtl/simon_pkg.sv
// Shared Simon types: lamp colour, sequencer state and the timer-width helper.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } seq_state_t;

  // Bits needed to hold the longer of the two phase reloads (value-1), never less than 1.
  function automatic int timer_width(input int on_ticks, input int off_ticks);
    int longest;
    int w;
    longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lamp_sequencer_if.sv
// Command/readback/lamp bus between the game controller (master) and the lamp sequencer (slave).
interface lamp_sequencer_if
  import simon_pkg::*;
#(
  parameter int LEN_W = 6
);

  // Commands are level-sampled on every clock edge while the sequencer is IDLE and are
  // silently dropped otherwise; there is no ready/acknowledge, BUSY and DONE tell the
  // master when commands are accepted again.
  logic             APPEND;
  color_t           RAND;
  logic             CLEAR;
  logic             PLAY;
  logic [LEN_W-1:0] RD_IDX;
  color_t           RD_DATA;
  color_t           OUT;
  logic             OUT_ENA;
  logic             BUSY;
  logic             DONE;
  logic [LEN_W-1:0] LEN;
  logic             FULL;
  seq_state_t       STATE;

  modport master (
    output APPEND, RAND, CLEAR, PLAY, RD_IDX,
    input  RD_DATA, OUT, OUT_ENA, BUSY, DONE, LEN, FULL, STATE
  );

  modport slave (
    input  APPEND, RAND, CLEAR, PLAY, RD_IDX,
    output RD_DATA, OUT, OUT_ENA, BUSY, DONE, LEN, FULL, STATE
  );

endinterface

// File: rtl/tick_timer.sv
// Loadable down-counter shared by the lamp ON and OFF phases; stops at zero.
module tick_timer #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic         ZERO
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign ZERO = (count == '0);

endmodule

// File: rtl/lamp_sequencer.sv
// Stores the Simon colour sequence and plays it on the lamp bus with fixed on/off phases.
module lamp_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int ON_TICKS  = 4000,
  parameter int OFF_TICKS = 1000,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input logic             CLK,
  input logic             RST,
  lamp_sequencer_if.slave bus
);

  localparam int TW = timer_width(ON_TICKS, OFF_TICKS);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TICKS - 1);

  seq_state_t       state;
  color_t           mem [MAX_LEN];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_next;
  logic [LEN_W-1:0] last_idx;
  color_t           out;
  color_t           rd_data;
  color_t           next_color;
  logic             out_ena;
  logic             busy;
  logic             done;
  logic             full;
  logic             do_clear;
  logic             do_append;
  logic             do_play;
  logic             timer_load;
  logic             timer_zero;
  logic [TW-1:0]    timer_val;

  // Priority CLEAR > APPEND > PLAY; losers in the same cycle are dropped.
  assign do_clear  = (state == IDLE) && bus.CLEAR;
  assign do_append = (state == IDLE) && !bus.CLEAR && bus.APPEND;
  assign do_play   = (state == IDLE) && !bus.CLEAR && !bus.APPEND && bus.PLAY;
  assign idx_next  = idx + LEN_W'(1);
  assign last_idx  = len - LEN_W'(1);

  always_comb begin
    rd_data    = '0;
    next_color = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bus.RD_IDX == LEN_W'(i)) rd_data = mem[i];
      if (idx_next == LEN_W'(i)) next_color = mem[i];
    end
  end

  always_comb begin
    timer_load = 1'b0;
    timer_val  = ON_LOAD;
    case (state)
      IDLE: timer_load = do_play && (len != '0);
      ON: begin
        timer_load = timer_zero;
        timer_val  = OFF_LOAD;
      end
      OFF: timer_load = timer_zero && (idx != last_idx);
      default: timer_load = 1'b0;
    endcase
  end

  tick_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (timer_load),
    .LOAD_VAL (timer_val),
    .ZERO     (timer_zero)
  );

  // Memory has no reset; only entries below LEN are meaningful.
  always_ff @(posedge CLK) begin
    if (!RST && do_append && !full) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (len == LEN_W'(i)) mem[i] <= bus.RAND;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      len     <= '0;
      full    <= 1'b0;
      idx     <= '0;
      out     <= '0;
      out_ena <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (do_clear) begin
            len  <= '0;
            full <= 1'b0;
          end else if (do_append) begin
            if (!full) begin
              len  <= len + LEN_W'(1);
              full <= (len == LEN_W'(MAX_LEN - 1));
            end
          end else if (do_play) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= ON;
              idx     <= '0;
              out     <= mem[0];
              out_ena <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ON: begin
          if (timer_zero) begin
            state   <= OFF;
            out_ena <= 1'b0;
          end
        end
        OFF: begin
          if (timer_zero) begin
            if (idx == last_idx) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= ON;
              idx     <= idx_next;
              out     <= next_color;
              out_ena <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RD_DATA = rd_data;
  assign bus.OUT     = out;
  assign bus.OUT_ENA = out_ena;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.LEN     = len;
  assign bus.FULL    = full;
  assign bus.STATE   = state;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Bench for lamp_sequencer: directed scenarios then random commands against a timeline model.
module tb_lamp_sequencer;
  import simon_pkg::*;

  localparam int MAX_LEN   = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  localparam int PERIOD    = ON_TICKS + OFF_TICKS;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lamp_sequencer_if #(.LEN_W(LEN_W)) bus ();

  lamp_sequencer #(
    .MAX_LEN   (MAX_LEN),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .LEN_W     (LEN_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // scoreboard: stored sequence plus playback position in cycles (-1 when idle)
  logic [1:0] exp_q[$];
  int         play_t = -1;
  logic       m_done = 1'b0;
  logic [1:0] m_out  = 2'd0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: playback is a timeline; cycle t of N*PERIOD shows element t/PERIOD, lit for the
  // first ON_TICKS cycles of each period, DONE when t reaches N*PERIOD.
  task automatic model_edge(input logic r, input logic a, input logic c, input logic p,
                            input logic [1:0] rnd);
    if (r) begin
      exp_q.delete();
      play_t = -1;
      m_done = 1'b0;
      m_out  = 2'd0;
    end else if (play_t >= 0) begin
      play_t++;
      m_done = 1'b0;
      if (play_t == exp_q.size() * PERIOD) begin
        play_t = -1;
        m_done = 1'b1;
      end else begin
        m_out = exp_q[play_t / PERIOD];
      end
    end else begin
      m_done = 1'b0;
      if (c) begin
        exp_q.delete();
      end else if (a) begin
        if (exp_q.size() < MAX_LEN) exp_q.push_back(rnd);
      end else if (p) begin
        if (exp_q.size() == 0) begin
          m_done = 1'b1;
        end else begin
          play_t = 0;
          m_out  = exp_q[0];
        end
      end
    end
  endtask

  // driver: one clock with the given inputs, then compare every output
  task automatic step(input logic r, input logic a, input logic c, input logic p,
                      input logic [1:0] rnd);
    logic       ena;
    logic       busy;
    seq_state_t st;
    int         ri;
    @(negedge CLK);
    RST        = r;
    bus.APPEND = a;
    bus.CLEAR  = c;
    bus.PLAY   = p;
    bus.RAND   = rnd;
    @(posedge CLK);
    model_edge(r, a, c, p, rnd);
    busy = (play_t >= 0);
    ena  = busy && ((play_t % PERIOD) < ON_TICKS);
    st   = !busy ? IDLE : (ena ? ON : OFF);
    #1;
    check("out_ena", 32'(bus.OUT_ENA), 32'(ena));
    check("busy",    32'(bus.BUSY),    32'(busy));
    check("done",    32'(bus.DONE),    32'(m_done));
    check("out",     32'(bus.OUT),     32'(m_out));
    check("len",     32'(bus.LEN),     32'(exp_q.size()));
    check("full",    32'(bus.FULL),    32'(exp_q.size() == MAX_LEN));
    check("state",   32'(bus.STATE),   32'(st));
    if (exp_q.size() > 0) begin
      ri = int'($urandom_range(0, exp_q.size() - 1));
      bus.RD_IDX = LEN_W'(ri);
      #1;
      check("rd_data", 32'(bus.RD_DATA), 32'(exp_q[ri]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'(i));
  endtask

  initial begin
    bus.APPEND = 1'b0;
    bus.CLEAR  = 1'b0;
    bus.PLAY   = 1'b0;
    bus.RAND   = 2'd0;
    bus.RD_IDX = '0;

    // reset and append 2,1,3
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    check("len_after_append", 32'(bus.LEN), 32'd3);
    // playback, plus an APPEND while busy
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(15);
    // full then empty playback
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'(i + 1));
    check("full_after_5", 32'(bus.FULL), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(2);
    // simultaneous commands
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    idle(2);
    // reset in the fourth cycle of playback, then append straight away
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    idle(2);

    // random phase
    for (int n = 0; n < 1500; n++) begin
      int roll;
      roll = int'($urandom_range(0, 99));
      step(roll < 2, roll >= 2 && roll < 45, (roll >= 45 && roll < 52) || roll == 99,
           (roll >= 52 && roll < 66) || (roll >= 30 && roll < 35), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

- Stores the Simon colour sequence and plays it back on the lamp bus with fixed on/off durations.
- Sits between `rng` and the lamp decode in the Simon top level. The game controller sequences it with APPEND/PLAY/CLEAR and reads it back through RD_IDX/RD_DATA to check player input.
- Runs entirely in the 10 kHz divided-clock domain.

## Interface
Parameters:
- MAX_LEN, 32: maximum sequence length, in elements.
- ON_TICKS, 4000: clocks each lamp stays lit (0.4 s at 10 kHz). Must be ≥1.
- OFF_TICKS, 1000: dark clocks after each element. Must be ≥1.
- LEN_W, $clog2(MAX_LEN+1): width of the length and index signals.

Ports:
- Clocking: one clock. Reset is synchronous and active-high.
- CLK  in  1  clock (10 kHz domain).
- RST  in  1  synchronous active-high reset.
- APPEND  in  1  append RAND to the end of the sequence.
- RAND  in  2  colour to append.
- CLEAR  in  1  empty the sequence.
- PLAY  in  1  start playback of the whole sequence.
- RD_IDX  in  LEN_W  readback index.
- RD_DATA  out  2  combinational mem[RD_IDX]. Undefined when RD_IDX ≥ LEN.
- OUT  out  2  colour currently shown.
- OUT_ENA  out  1  lamp lit.
- BUSY  out  1  playback in progress.
- DONE  out  1  single-cycle pulse at the end of playback.
- LEN  out  LEN_W  current sequence length.
- FULL  out  1  LEN == MAX_LEN.

## Operation
- **Reset values:** state IDLE; LEN=0; OUT=0; OUT_ENA=0; BUSY=0; DONE=0; index=0; timer=0. Memory contents are not cleared.
- **Commands:** sampled only in IDLE; ignored while BUSY.
- **Command priority in one cycle:** CLEAR > APPEND > PLAY. A lower-priority command in the same cycle is dropped, not deferred.
- **APPEND:** writes mem[LEN]=RAND and increments LEN. Ignored when FULL.
- **CLEAR:** sets LEN=0.
- **PLAY with LEN=0:** no lamp activity. DONE pulses the next cycle and the block stays IDLE.
- **State machine (IDLE, ON, OFF):**
  - IDLE→ON on PLAY with LEN>0: idx=0, OUT=mem[0], OUT_ENA=1, BUSY=1, timer=ON_TICKS-1.
  - ON: decrement timer. At timer==0 → OFF with OUT_ENA=0 and timer=OFF_TICKS-1. OUT holds its value.
  - OFF: decrement timer. At timer==0:
    - if idx==LEN-1 → IDLE with BUSY=0 and DONE=1 for one cycle;
    - otherwise idx++, OUT=mem[idx+1], OUT_ENA=1, timer=ON_TICKS-1 → ON.
- **Registered outputs:** OUT, OUT_ENA, BUSY and DONE are all registered. RD_DATA is the only combinational output.
- **Width rules:**
  - idx and LEN are LEN_W bits wide; LEN never exceeds MAX_LEN.
  - The timer is $clog2(max(ON_TICKS,OFF_TICKS)) bits wide, minimum 1 bit.
- **RST mid-playback:** abort immediately. All outputs return to their reset values on the next edge. No DONE pulse.

## Timing
- **Start:** with PLAY sampled at edge 0, OUT_ENA is 1 from edge 0 through edge ON_TICKS-1.
- **Per element:** OUT_ENA is high for exactly ON_TICKS cycles, then low for exactly OFF_TICKS cycles.
- **Transitions between elements:**
  - OUT changes only on the edge where OUT_ENA rises.
  - There is no glitch or overlap between consecutive elements.
- **End of sequence:** for N elements, DONE=1 in the cycle following edge N·(ON_TICKS+OFF_TICKS). BUSY falls on the same edge.
- **Next command:** a new PLAY/APPEND/CLEAR is accepted in the cycle DONE is high, because the block is already IDLE.
- **Latencies:**
  - APPEND is visible on LEN and RD_DATA one edge after it is sampled.
  - FULL updates on the same edge as LEN.

## Structure
- **Shared package `simon_pkg`:**
  - `color_t` (logic [1:0]), also used by rng, io_sync and controller;
  - `seq_state_t` enum {IDLE, ON, OFF}.
- **Sub-module `tick_timer`:**
  - loadable down-counter with LOAD and LOAD_VAL inputs and a ZERO flag;
  - instantiated once and reused for both ON and OFF phases.
- **Memory:** MAX_LEN×2 flop array, written at index LEN.

## Test plan
All scenarios use MAX_LEN=4, ON_TICKS=3, OFF_TICKS=2.

1. **Reset and append.** RST, then APPEND with RAND=2,1,3.
   - LEN=3, FULL=0.
   - RD_DATA at indices 0/1/2 = 2/1/3.
   - All outputs 0 after reset.
2. **Playback.** PLAY at edge 0 with sequence {2,1,3}.
   - OUT_ENA pattern 1110011100111 00; OUT=2,1,3 during the lit cycles.
   - DONE pulses once, 15 cycles after PLAY; BUSY high throughout.
3. **Full and empty.**
   - 5 APPENDs: LEN=4, FULL=1, 5th value not stored.
   - CLEAR then PLAY: DONE one cycle after PLAY, OUT_ENA never 1.
4. **Simultaneous commands.**
   - CLEAR+APPEND in the same cycle: LEN=0.
   - APPEND+PLAY in the same cycle: LEN increments, BUSY stays 0.
   - APPEND during BUSY: LEN unchanged.
5. **Reset mid-playback.** RST asserted in cycle 4 of playback.
   - Next edge: OUT_ENA=0, BUSY=0, LEN=0.
   - No DONE pulse; the block accepts APPEND immediately after RST deasserts.
